// File: rtl/ram_arbiter.sv
// Three-port arbiter and access sequencer for the shared single-port program/data RAM.
// One registered access per three-cycle slot; fixed LD > CPU > PNL priority with a PNL starvation guard.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 12,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_ack,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  pnl_req,
  input  logic                  pnl_we,
  input  logic [ADDR_WIDTH-1:0] pnl_addr,
  input  logic [DATA_WIDTH-1:0] pnl_wdata,
  output logic                  pnl_ack,
  output logic [DATA_WIDTH-1:0] pnl_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy
);

  // state | meaning
  // IDLE  | waiting for a request; arbitration happens on the edge leaving here
  // SERVE | RAM address/data/we driven for the granted requester
  // ACK   | winner's ack pulses; read data already captured
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  localparam logic [1:0] W_LD  = 2'd0;
  localparam logic [1:0] W_CPU = 2'd1;
  localparam logic [1:0] W_PNL = 2'd2;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [1:0]            state;
  logic [1:0]            win;
  logic [3:0]            starve;
  logic [1:0]            pick;
  logic                  any_req;
  logic                  force_pnl;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_din;
  logic                  sel_we;

  assign any_req   = ld_req | cpu_req | pnl_req;
  // LD is never overridden; only CPU yields to a starved PNL
  assign force_pnl = pnl_req && !ld_req && (starve == WAIT_LIMIT);
  assign busy      = (state == SERVE) || (state == ACK);

  always_comb begin
    pick = W_PNL;
    if (ld_req)
      pick = W_LD;
    else if (cpu_req && !force_pnl)
      pick = W_CPU;
  end

  always_comb begin
    sel_addr = pnl_addr;
    sel_din  = pnl_wdata;
    sel_we   = pnl_we;
    case (pick)
      W_LD: begin
        sel_addr = ld_addr;
        sel_din  = ld_wdata;
        sel_we   = ld_we;
      end
      W_CPU: begin
        sel_addr = cpu_addr;
        sel_din  = cpu_wdata;
        sel_we   = cpu_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      win       <= W_LD;
      starve    <= 4'd0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we    <= 1'b0;
      ld_ack    <= 1'b0;
      cpu_ack   <= 1'b0;
      pnl_ack   <= 1'b0;
      ld_rdata  <= '0;
      cpu_rdata <= '0;
      pnl_rdata <= '0;
    end else begin
      ld_ack  <= 1'b0;
      cpu_ack <= 1'b0;
      pnl_ack <= 1'b0;
      ram_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= SERVE;
            win      <= pick;
            ram_addr <= sel_addr;
            ram_din  <= sel_din;
            ram_we   <= sel_we;
            if (!pnl_req || pick == W_PNL)
              starve <= 4'd0;
            else if (pick == W_CPU)
              starve <= starve + 4'd1;
          end
        end
        SERVE: begin
          state <= ACK;
          // ram_we here is the registered enable of the access in flight
          case (win)
            W_LD: begin
              ld_ack <= 1'b1;
              if (!ram_we) ld_rdata <= ram_dout;
            end
            W_CPU: begin
              cpu_ack <= 1'b1;
              if (!ram_we) cpu_rdata <= ram_dout;
            end
            default: begin
              pnl_ack <= 1'b1;
              if (!ram_we) pnl_rdata <= ram_dout;
            end
          endcase
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 256x12 RAM and hand-computed expectations.
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_req = 1'b0, ld_we = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, pnl_req = 1'b0, pnl_we = 1'b0;
  logic [7:0]  ld_addr = '0, cpu_addr = '0, pnl_addr = '0;
  logic [11:0] ld_wdata = '0, cpu_wdata = '0, pnl_wdata = '0;
  logic        ld_ack, cpu_ack, pnl_ack;
  logic [11:0] ld_rdata, cpu_rdata, pnl_rdata;
  logic [7:0]  ram_addr;
  logic [11:0] ram_din, ram_dout;
  logic        ram_we, busy;

  logic [11:0] mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [11:0] pre_data = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(12), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .pnl_req(pnl_req), .pnl_we(pnl_we), .pnl_addr(pnl_addr), .pnl_wdata(pnl_wdata),
    .pnl_ack(pnl_ack), .pnl_rdata(pnl_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .busy(busy)
  );

  // RAM write port shares the system reset, so a write in flight when reset hits is not committed
  assign ram_dout = mem[ram_addr];
  always @(posedge clk) begin
    if (pre_we)
      mem[pre_addr] <= pre_data;
    else if (ram_we && rst_n)
      mem[ram_addr] <= ram_din;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [11:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic drive(input int p, input logic r, input logic we, input logic [7:0] a, input logic [11:0] d);
    case (p)
      0: begin ld_req = r;  ld_we = we;  ld_addr = a;  ld_wdata = d;  end
      1: begin cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
      default: begin pnl_req = r; pnl_we = we; pnl_addr = a; pnl_wdata = d; end
    endcase
  endtask

  function automatic logic ack_of(input int p);
    case (p)
      0: return ld_ack;
      1: return cpu_ack;
      default: return pnl_ack;
    endcase
  endfunction

  task automatic access(input int p, input logic we, input logic [7:0] a, input logic [11:0] d, input string tag);
    int n;
    n = 0;
    drive(p, 1'b1, we, a, d);
    repeat (10) begin
      @(negedge clk);
      n++;
      if (ack_of(p)) break;
    end
    check({tag, " ack latency"}, n, 2);
    drive(p, 1'b0, we, a, d);
    @(negedge clk);
  endtask

  initial begin
    int exp_seq [9];
    int n;
    int got;
    exp_seq = '{1, 1, 1, 1, 0, 0, 0, 2, 1};

    preload(8'h05, 12'hB03);
    preload(8'h10, 12'h111);
    preload(8'h11, 12'h222);
    preload(8'h12, 12'h333);
    preload(8'h13, 12'h444);
    preload(8'h40, 12'h0AA);
    @(negedge clk);
    check("rst acks", {ld_ack, cpu_ack, pnl_ack}, 0);
    check("rst rdata", {ld_rdata, cpu_rdata, pnl_rdata}, 0);
    check("rst ram_addr", ram_addr, 0);
    check("rst ram_din", ram_din, 0);
    check("rst ram_we", ram_we, 0);
    check("rst busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // CPU read of a preloaded word
    drive(1, 1'b1, 1'b0, 8'h05, 12'h0);
    @(negedge clk);
    check("t1 busy serve", busy, 1);
    check("t1 ram_addr", ram_addr, 8'h05);
    check("t1 ram_we", ram_we, 0);
    check("t1 early ack", cpu_ack, 0);
    @(negedge clk);
    check("t1 cpu_ack", cpu_ack, 1);
    check("t1 cpu_rdata", cpu_rdata, 12'hB03);
    check("t1 busy ack", busy, 1);
    drive(1, 1'b0, 1'b0, 8'h05, 12'h0);
    @(negedge clk);
    check("t1 ack pulse", cpu_ack, 0);
    check("t1 busy idle", busy, 0);

    // LD write then CPU read back
    drive(0, 1'b1, 1'b1, 8'h2A, 12'hABC);
    @(negedge clk);
    check("t2 ram_we", ram_we, 1);
    check("t2 ram_addr", ram_addr, 8'h2A);
    check("t2 ram_din", ram_din, 12'hABC);
    @(negedge clk);
    check("t2 ram_we drop", ram_we, 0);
    check("t2 ld_ack", ld_ack, 1);
    check("t2 ld_rdata", ld_rdata, 0);
    check("t2 mem", mem[8'h2A], 12'hABC);
    drive(0, 1'b0, 1'b1, 8'h2A, 12'hABC);
    @(negedge clk);
    check("t2 busy idle", busy, 0);
    access(1, 1'b0, 8'h2A, 12'h0, "t2 cpu read");
    check("t2 cpu_rdata", cpu_rdata, 12'hABC);

    // Three-way contention: acks after edges k+1, k+4, k+7
    drive(0, 1'b1, 1'b0, 8'h10, 12'h0);
    drive(1, 1'b1, 1'b0, 8'h11, 12'h0);
    drive(2, 1'b1, 1'b0, 8'h12, 12'h0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("t3 acks cycle %0d", i), {ld_ack, cpu_ack, pnl_ack},
            (i == 1) ? 3'b100 : (i == 4) ? 3'b010 : (i == 7) ? 3'b001 : 3'b000);
      if (ld_ack) begin
        check("t3 ld_rdata", ld_rdata, 12'h111);
        drive(0, 1'b0, 1'b0, 8'h10, 12'h0);
      end
      if (cpu_ack) begin
        check("t3 cpu_rdata", cpu_rdata, 12'h222);
        drive(1, 1'b0, 1'b0, 8'h11, 12'h0);
      end
      if (pnl_ack) begin
        check("t3 pnl_rdata", pnl_rdata, 12'h333);
        drive(2, 1'b0, 1'b0, 8'h12, 12'h0);
      end
    end
    check("t3 busy idle", busy, 0);

    // Starvation guard: 4 CPU grants, LD still wins while held, then PNL, then CPU
    drive(1, 1'b1, 1'b0, 8'h11, 12'h0);
    drive(2, 1'b1, 1'b0, 8'h12, 12'h0);
    n = 0;
    for (int c = 0; c < 60 && n < 9; c++) begin
      @(negedge clk);
      if (ld_ack || cpu_ack || pnl_ack) begin
        got = ld_ack ? 0 : (cpu_ack ? 1 : 2);
        check($sformatf("t4 slot %0d winner", n), got, exp_seq[n]);
        n++;
        if (n == 4) drive(0, 1'b1, 1'b0, 8'h10, 12'h0);
        if (n == 7) drive(0, 1'b0, 1'b0, 8'h10, 12'h0);
        if (n == 8) drive(2, 1'b0, 1'b0, 8'h12, 12'h0);
        if (n == 9) drive(1, 1'b0, 1'b0, 8'h11, 12'h0);
      end
    end
    check("t4 slots served", n, 9);
    drive(0, 1'b0, 1'b0, 8'h10, 12'h0);
    drive(1, 1'b0, 1'b0, 8'h11, 12'h0);
    drive(2, 1'b0, 1'b0, 8'h12, 12'h0);
    @(negedge clk);

    // Reset in the middle of a write
    drive(1, 1'b1, 1'b1, 8'h40, 12'h555);
    @(negedge clk);
    check("t5 ram_we serve", ram_we, 1);
    rst_n = 1'b0;
    drive(1, 1'b0, 1'b1, 8'h40, 12'h555);
    @(negedge clk);
    check("t5 ram_we after rst", ram_we, 0);
    check("t5 busy after rst", busy, 0);
    check("t5 no ack", cpu_ack, 0);
    check("t5 mem kept", mem[8'h40], 12'h0AA);
    check("t5 rdata cleared", cpu_rdata, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t5 still no ack", cpu_ack, 0);
    access(1, 1'b1, 8'h40, 12'h555, "t5 fresh write");
    check("t5 mem written", mem[8'h40], 12'h555);
    access(1, 1'b0, 8'h40, 12'h0, "t5 read back");
    check("t5 cpu_rdata", cpu_rdata, 12'h555);

    // Requester drops req during SERVE
    drive(2, 1'b1, 1'b0, 8'h13, 12'h0);
    @(negedge clk);
    check("t6 busy serve", busy, 1);
    drive(2, 1'b0, 1'b0, 8'h13, 12'h0);
    @(negedge clk);
    check("t6 pnl_ack", pnl_ack, 1);
    check("t6 pnl_rdata", pnl_rdata, 12'h444);
    @(negedge clk);
    check("t6 ack pulse", pnl_ack, 0);
    check("t6 busy idle", busy, 0);
    @(negedge clk);
    check("t6 no extra slot", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
